// File: rtl/hid_bt_link.sv
// hid_bt_link: HID link front end for retro_paint.
// UART 8N1 receiver feeding a 3-byte Bluetooth command-frame decoder
// (header byte 11xx_xccc, then X byte, then Y byte, 6 bits each).
// Optional inter-byte frame timeout: define BT_FRAME_TIMEOUT_EN.
module hid_bt_link #(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
`ifdef BT_FRAME_TIMEOUT_EN
  ,
  parameter int TIMEOUT_BITS = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic [2:0] command_id,
  output logic [5:0] x_out,
  output logic [5:0] y_out,
  output logic       data_ready
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_X, WAIT_Y} dec_state_t;

  logic              rx_meta;
  logic              rx_sync;
  uart_state_t       uart_state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;

  dec_state_t        dec_state;
  logic [2:0]        cmd_pend;
  logic [5:0]        x_pend;
  logic              is_header;
  logic              frame_timeout;

  // Two-flop synchronizer; presets to idle-high so reset never fakes a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // UART receive FSM: start-bit qualify at mid-bit, then sample each bit centre
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_state <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_valid   <= 1'b0;
      rx_byte    <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (uart_state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rx_sync) uart_state <= START;
        end
        START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt    <= '0;
            bit_idx    <= '0;
            // still high at mid-bit means the falling edge was a glitch
            uart_state <= rx_sync ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) uart_state <= STOP;
            else                 bit_idx    <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            // a low stop bit is a framing error: drop the byte silently
            if (rx_sync) begin
              rx_byte  <= shift_reg;
              rx_valid <= 1'b1;
            end
            uart_state <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: uart_state <= IDLE;
      endcase
    end
  end

  // Data shift register, LSB first; contents only matter once all 8 bits are in
  always_ff @(posedge clk) begin
    if (uart_state == DATA && bit_cnt == BIT_LAST) shift_reg[bit_idx] <= rx_sync;
  end

  assign is_header = (rx_byte[7:6] == 2'b11);

`ifdef BT_FRAME_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W   = $clog2(TO_CYC + 1);

  logic [TO_W-1:0] to_cnt;

  // Inter-byte timer: runs only while a frame is partially received
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (rx_valid || dec_state == WAIT_CMD) begin
      to_cnt <= '0;
    end else if (!frame_timeout) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign frame_timeout = (dec_state != WAIT_CMD) && (to_cnt == TO_W'(TO_CYC - 1));
`else
  assign frame_timeout = 1'b0;
`endif

  // Pending command / X of the frame in progress; stale values are harmless
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      if (is_header)               cmd_pend <= rx_byte[2:0];
      else if (dec_state == WAIT_X) x_pend  <= rx_byte[5:0];
    end
  end

  // Frame decoder: a header always (re)starts a frame; Y byte publishes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_state  <= WAIT_CMD;
      command_id <= '0;
      x_out      <= '0;
      y_out      <= '0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      if (rx_valid) begin
        if (is_header) begin
          dec_state <= WAIT_X;
        end else begin
          case (dec_state)
            WAIT_X: dec_state <= WAIT_Y;
            WAIT_Y: begin
              command_id <= cmd_pend;
              x_out      <= x_pend;
              y_out      <= rx_byte[5:0];
              data_ready <= 1'b1;
              dec_state  <= WAIT_CMD;
            end
            default: dec_state <= WAIT_CMD;
          endcase
        end
      end else if (frame_timeout) begin
        dec_state <= WAIT_CMD;
      end
    end
  end

endmodule

// File: tb/tb_hid_bt_link.sv
// tb_hid_bt_link: directed bench for hid_bt_link at a reduced bit rate
// (16 clocks per bit). Covers BT_FRAME_TIMEOUT_EN when that macro is defined.
module tb_hid_bt_link;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [2:0] command_id;
  logic [5:0] x_out;
  logic [5:0] y_out;
  logic       data_ready;

  int n_cmp;
  int n_err;
  int rxv_cnt;
  int dr_cnt;
  logic [7:0] rx_log[$];

  hid_bt_link #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .command_id (command_id),
    .x_out      (x_out),
    .y_out      (y_out),
    .data_ready (data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe cycles and log received bytes, sampled mid-cycle
  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      rx_log.push_back(rx_byte);
    end
    if (data_ready) dr_cnt <= dr_cnt + 1;
  end

  // Hard time limit so the run always ends
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop bit, then one idle bit
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    send_bit(1'b1);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] c, input logic [5:0] x, input logic [5:0] y);
    chk_eq({tag, "_cmd"}, 32'(command_id), 32'(c));
    chk_eq({tag, "_x"},   32'(x_out),      32'(x));
    chk_eq({tag, "_y"},   32'(y_out),      32'(y));
  endtask

  int rv0;
  int dr0;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rxv_cnt = 0;
    dr_cnt  = 0;
    rx      = 1'b1;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk_eq("rst_rx_byte", 32'(rx_byte), 32'h0);
    chk_eq("rst_data_ready", 32'(data_ready), 32'd0);
    chk_out("rst", 3'd0, 6'd0, 6'd0);
    reset = 1'b0;
    idle_bits(2);

    // Nominal frame C1 23 32 -> move to (35,50)
    rv0 = rxv_cnt; dr0 = dr_cnt;
    send_byte(8'hC1, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h32, 1'b1);
    chk_eq("nom_rxv_cnt", 32'(rxv_cnt - rv0), 32'd3);
    chk_eq("nom_byte0", 32'(rx_log[rv0]),     32'hC1);
    chk_eq("nom_byte1", 32'(rx_log[rv0 + 1]), 32'h23);
    chk_eq("nom_byte2", 32'(rx_log[rv0 + 2]), 32'h32);
    chk_eq("nom_rx_byte", 32'(rx_byte), 32'h32);
    chk_eq("nom_dr_cnt", 32'(dr_cnt - dr0), 32'd1);
    chk_out("nom", 3'd1, 6'd35, 6'd50);

    // Glitch: low for a quarter bit only
    rv0 = rxv_cnt; dr0 = dr_cnt;
    rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    idle_bits(3);
    chk_eq("glitch_rxv_cnt", 32'(rxv_cnt - rv0), 32'd0);
    chk_eq("glitch_dr_cnt", 32'(dr_cnt - dr0), 32'd0);
    chk_eq("glitch_rx_byte", 32'(rx_byte), 32'h32);
    chk_out("glitch", 3'd1, 6'd35, 6'd50);

    // Framing error inside a frame: C5, 23(bad stop), 23, 32
    rv0 = rxv_cnt; dr0 = dr_cnt;
    send_byte(8'hC5, 1'b1);
    send_byte(8'h23, 1'b0);
    chk_eq("ferr_rxv_cnt", 32'(rxv_cnt - rv0), 32'd1);
    chk_eq("ferr_rx_byte", 32'(rx_byte), 32'hC5);
    chk_eq("ferr_dr_cnt", 32'(dr_cnt - dr0), 32'd0);
    send_byte(8'h23, 1'b1);
    send_byte(8'h32, 1'b1);
    chk_eq("ferr_rxv_total", 32'(rxv_cnt - rv0), 32'd3);
    chk_eq("ferr_byte1", 32'(rx_log[rv0 + 1]), 32'h23);
    chk_eq("ferr_dr_total", 32'(dr_cnt - dr0), 32'd1);
    chk_out("ferr", 3'd5, 6'd35, 6'd50);

    // Resync: a new header mid-frame restarts it
    dr0 = dr_cnt;
    send_byte(8'hC1, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'hC2, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h07, 1'b1);
    chk_eq("resync_dr_cnt", 32'(dr_cnt - dr0), 32'd1);
    chk_out("resync", 3'd2, 6'd5, 6'd7);

    // Stray data byte with no header
    rv0 = rxv_cnt; dr0 = dr_cnt;
    send_byte(8'h23, 1'b1);
    chk_eq("stray_rxv_cnt", 32'(rxv_cnt - rv0), 32'd1);
    chk_eq("stray_rx_byte", 32'(rx_byte), 32'h23);
    chk_eq("stray_dr_cnt", 32'(dr_cnt - dr0), 32'd0);
    chk_out("stray", 3'd2, 6'd5, 6'd7);

    // Reset mid-frame discards the partial frame
    dr0 = dr_cnt;
    send_byte(8'hC1, 1'b1);
    send_byte(8'h23, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_eq("mrst_rx_byte", 32'(rx_byte), 32'h0);
    chk_out("mrst", 3'd0, 6'd0, 6'd0);
    rv0 = rxv_cnt;
    send_byte(8'h32, 1'b1);
    chk_eq("mrst_rxv_cnt", 32'(rxv_cnt - rv0), 32'd1);
    chk_eq("mrst_dr_cnt", 32'(dr_cnt - dr0), 32'd0);
    chk_out("mrst_after", 3'd0, 6'd0, 6'd0);

    // Long inter-byte gap: dropped with the timeout, tolerated without it
    dr0 = dr_cnt;
    send_byte(8'hC1, 1'b1);
    send_byte(8'h23, 1'b1);
    idle_bits(40);
    send_byte(8'h32, 1'b1);
`ifdef BT_FRAME_TIMEOUT_EN
    chk_eq("tmo_dr_cnt", 32'(dr_cnt - dr0), 32'd0);
    chk_out("tmo", 3'd0, 6'd0, 6'd0);
    dr0 = dr_cnt;
    send_byte(8'hC1, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h32, 1'b1);
    chk_eq("tmo_next_dr_cnt", 32'(dr_cnt - dr0), 32'd1);
    chk_out("tmo_next", 3'd1, 6'd35, 6'd50);
`else
    chk_eq("gap_dr_cnt", 32'(dr_cnt - dr0), 32'd1);
    chk_out("gap", 3'd1, 6'd35, 6'd50);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hid_bt_link.md
Name: hid_bt_link

Overview:
- HID link front end for retro_paint: one block holding a UART 8N1 receiver and a Bluetooth command-frame decoder.
- Turns the serial line from the BT module into decoded commands with 6-bit X/Y cursor coordinates.
- A 3-byte frame produces command_id, x_out and y_out, plus a one-cycle data_ready strobe, for the paint controller.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (2604), clock cycles per bit, integer division.
- TIMEOUT_BITS, 32, inter-byte timeout in bit periods; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- rx_valid  out  1  one-cycle pulse when a byte is received.
- rx_byte  out  8  last received byte; held until the next byte.
- command_id  out  3  command of the last complete frame.
- x_out  out  6  X coordinate of the last complete frame.
- y_out  out  6  Y coordinate of the last complete frame.
- data_ready  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, reset).
  - All outputs go to 0 and both FSMs go to idle.
  - The rx synchronizer presets to 1.
  - Reset mid-byte or mid-frame discards any partial data.
- Input sync: rx passes through a 2-flop synchronizer; all rx logic uses the synchronized value.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: a low level moves to START and clears the counter.
  - START: at CLKS_PER_BIT/2 (mid-bit), resample. Low moves to DATA; high is a glitch and returns to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first, shifted into bit [i].
  - STOP: after CLKS_PER_BIT cycles, sample.
    - Sample 1: rx_byte updates and rx_valid pulses for exactly one cycle.
    - Sample 0: framing error, byte dropped, no pulse.
    - Either way, return to IDLE immediately. A new start bit half a bit after the stop-bit sample is accepted.
  - Latency: rx_valid occurs about 9.5 bit times plus 2 to 3 cycles after the start-bit falling edge.
- Decoder FSM, states WAIT_CMD, WAIT_X, WAIT_Y; advances only on rx_valid:
  - Header byte: rx_byte[7:6] == 2'b11. Bits [2:0] are the command id; bits [5:3] are ignored.
  - WAIT_CMD: a header latches the pending command and moves to WAIT_X. Any other byte is ignored.
  - WAIT_X: a header restarts the frame (latch the new command, stay in WAIT_X). Otherwise latch pending x = byte[5:0] and move to WAIT_Y.
  - WAIT_Y: a header restarts the frame and goes to WAIT_X. Otherwise, on the next clock:
    - command_id, x_out and y_out = byte[5:0] load together;
    - data_ready pulses for one cycle;
    - the FSM returns to WAIT_CMD.
  - command_id, x_out and y_out change only at frame completion and hold otherwise. Data-byte bits [7:6] are discarded.
  - Framing-error bytes never reach the decoder.
- Frame example: command 0xC1 means "move". Frame C1, 23, 32 gives command_id=1, x_out=35, y_out=50.

Optional Feature:
- Macro BT_FRAME_TIMEOUT_EN.
- Defined:
  - A counter runs while the decoder is in WAIT_X or WAIT_Y. It clears on each rx_valid.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT cycles, the decoder returns to WAIT_CMD and the partial frame is dropped. Outputs are unchanged and there is no data_ready.
- Undefined: no timeout; the decoder waits indefinitely.

Test Plan:
- Nominal frame: send C1, 23, 32 at 9600 baud, 1 bit idle between bytes -> three rx_valid pulses with rx_byte C1, 23, 32; then command_id=1, x_out=35, y_out=50; exactly one data_ready pulse.
- Glitch: rx low for CLKS_PER_BIT/4 cycles, then high -> no rx_valid, outputs unchanged.
- Framing error: byte 0x23 with stop bit 0 inside a frame -> no rx_valid; decoder state unchanged; then 23, 32 complete the frame normally.
- Resync: send C1, 23, C2, 05, 07 -> one data_ready; command_id=2, x_out=5, y_out=7.
- Stray data and reset:
  - Send 23 alone -> no data_ready.
  - Send C1, 23, assert reset, release, send 32 -> no data_ready; all outputs 0.
- With BT_FRAME_TIMEOUT_EN: send C1, 23, idle 40 bit times, then 32 -> no data_ready. Then C1, 23, 32 -> data_ready with 1/35/50.
